dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters. Port 0 is the CPU control FSM's load/store path (LW/SW). Port 1 is the debug/program-loader port.
- Arbitrates with round-robin, latches the winning request, and drives the RAM strobes for exactly one cycle.
- Sequences the fixed RAM read latency and returns read data to the requester that was granted.
- Sits between the control/ALU datapath and data_RAM, replacing the direct mem_rd/mem_wr connection.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- RD_LAT, 1, cycles from the mem_rd cycle to valid mem_rdata. Legal range 1..4.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  port 0 (CPU) request pending.
- req0_we  input  1  port 0 write (1) or read (0).
- req0_addr  input  AW  port 0 byte address.
- req0_wdata  input  DW  port 0 write data.
- req0_ready  output  1  port 0 request accepted; one-cycle pulse.
- req0_err  output  1  port 0 request rejected as misaligned; pulses together with ready.
- req0_rvalid  output  1  port 0 read data valid; one-cycle pulse.
- req0_rdata  output  DW  port 0 read data; held until the next port 0 read completes.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_err, req1_rvalid, req1_rdata: same as port 0, for port 1 (debug/loader).
- mem_rd  output  1  RAM read strobe.
- mem_wr  output  1  RAM write strobe.
- mem_addr  output  AW  RAM address.
- mem_wdata  output  DW  RAM write data.
- mem_rdata  input  DW  RAM read data.

Behaviour:
- Reset values: all outputs 0, including rdata registers, mem_addr and mem_wdata. State=IDLE, last_grant=1, so port 0 wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No valid: stay in IDLE.
  - One valid: grant that port.
  - Both valid: grant the port that is not last_grant.
  - On grant: latch port id, we, addr and wdata; set last_grant to the granted port; go to ISSUE.
- ISSUE (one cycle):
  - granted reqN_ready=1.
  - If latched addr[1:0]!=0: reqN_err=1, no RAM strobe, go to IDLE.
  - Else if we=1: mem_wr=1, go to IDLE.
  - Else: mem_rd=1, load countdown with RD_LAT, go to WAIT.
- WAIT:
  - mem_addr stays held; mem_rd=0.
  - Countdown decrements each cycle.
  - In the cycle where the count reaches 1: capture mem_rdata into the granted port's rdata register, go to RESP.
  - WAIT lasts exactly RD_LAT cycles.
- RESP (one cycle): granted reqN_rvalid=1, go to IDLE.
- Outputs:
  - mem_addr and mem_wdata come from the latched request and are stable from ISSUE through the end of WAIT.
  - Ready, err, rvalid and strobes are all single-cycle pulses and never overlap across ports.
- Latency:
  - Write: valid sampled in IDLE at cycle t, mem_wr and ready at t+1, next arbitration at t+2.
  - Read: mem_rd and ready at t+1, rvalid at t+2+RD_LAT.
- Requester protocol:
  - Hold valid, we, addr and wdata stable until ready is sampled high.
  - Deassert valid, or present the next request, in the cycle after ready.
- Protocol violation: if valid drops after the grant but before ready, the latched transaction still completes, including rvalid for reads.
- Non-granted port: its valid is ignored until the next IDLE cycle. It is re-evaluated there and wins by round-robin if the other port is also valid.
- Fairness: no port waits more than one full transaction of the other port.
- Reset mid-operation: immediate return to IDLE. Strobes drop asynchronously and the pending read is dropped (no rvalid). RAM contents are not this block's concern.

Test Plan:
- Reset, then port 0 write addr=0x10 wdata=0xDEADBEEF -> req0_ready and mem_wr high in the same cycle (t+1), mem_addr=0x10, no rvalid. Follow with port 0 read of 0x10 (RAM model RD_LAT=1) -> req0_rvalid at t+3, req0_rdata=0xDEADBEEF.
- Both ports valid every cycle with reads at 0x0 and 0x4 -> grants alternate 0,1,0,1 and port 0 is first. Each rvalid appears only on its own port with the correct data.
- Port 1 read 0x8 pending; port 0 raises valid during WAIT -> port 0 is granted in the IDLE after RESP. req0_rdata is unchanged until its own rvalid.
- Misaligned port 1 write addr=0x6 -> req1_ready=1 and req1_err=1 in the same cycle, mem_wr stays 0, no rvalid. A subsequent aligned request proceeds normally.
- RD_LAT=3: read 0x20 -> mem_rd for 1 cycle, mem_addr held for 3 WAIT cycles, rvalid exactly 5 cycles after valid was sampled.
- Assert rst during WAIT of a port 0 read -> mem_rd and mem_addr go to 0 immediately, no rvalid ever arrives, first post-reset tie goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data RAM between two requesters:
//   port 0 - CPU control FSM load/store path (LW/SW)
//   port 1 - debug / program-loader port
//
// A round-robin arbiter picks one pending request in IDLE and latches it.
// The latched request then drives the RAM for exactly one ISSUE cycle. Reads
// wait out the fixed RAM latency in WAIT. The read data is then returned to
// the granted port in RESP.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   reqN_valid/we/addr/wdata   request from port N (held until reqN_ready)
//   reqN_ready           one-cycle accept pulse
//   reqN_err             pulses with ready when the address is misaligned
//   reqN_rvalid          one-cycle read-data-valid pulse
//   reqN_rdata           last read data returned to port N (held)
//   mem_rd/mem_wr        single-cycle RAM strobes
//   mem_addr/mem_wdata   RAM address / write data from the latched request
//   mem_rdata            RAM read data, valid RD_LAT cycles after mem_rd
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1    // legal range 1..4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_err,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,

    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_err,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,

    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] RD_LAT_CNT = 3'(RD_LAT);

    state_t        state;
    state_t        state_nxt;

    logic          last_grant;  // port granted most recently; loses the next tie
    logic          gnt_port;    // port owning the transaction in flight
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [2:0]    cnt;         // remaining WAIT cycles, including the current one
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          any_valid;
    logic          pick;
    logic          misaligned;

    // Round-robin pick. Only looked at in IDLE. A single valid port wins
    // outright. On a tie the port that was not granted last time wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            pick = ~last_grant;
        end else begin
            pick = req1_valid;
        end
    end

    // Word accesses only; any low address bit set rejects the request.
    assign misaligned = |lat_addr[1:0];

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = (misaligned || lat_we) ? IDLE : WAIT;
            WAIT:    if (cnt == 3'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (pure decode of the registered state)
    // -----------------------------------------------------------------------
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        req0_err    = 1'b0;
        req1_err    = 1'b0;
        req0_rvalid = 1'b0;
        req1_rvalid = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        case (state)
            ISSUE: begin
                req0_ready = ~gnt_port;
                req1_ready =  gnt_port;
                req0_err   = ~gnt_port & misaligned;
                req1_err   =  gnt_port & misaligned;
                mem_wr     = ~misaligned &  lat_we;
                mem_rd     = ~misaligned & ~lat_we;
            end
            RESP: begin
                req0_rvalid = ~gnt_port;
                req1_rvalid =  gnt_port;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Request latch, latency countdown and per-port read data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            gnt_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt_port   <= pick;
                        last_grant <= pick;
                        lat_we     <= pick ? req1_we    : req0_we;
                        lat_addr   <= pick ? req1_addr  : req0_addr;
                        lat_wdata  <= pick ? req1_wdata : req0_wdata;
                    end
                end
                ISSUE: begin
                    cnt <= RD_LAT_CNT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    // Last WAIT cycle: RAM data is valid now.
                    if (cnt == 3'd1) begin
                        if (gnt_port) begin
                            rdata1_q <= mem_rdata;
                        end else begin
                            rdata0_q <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The address and write data come straight from the latch. This keeps
    // them stable from ISSUE through WAIT. They also clear with reset.
    assign mem_addr   = lat_addr;
    assign mem_wdata  = lat_wdata;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT with RD_LAT=1 ----------------
    logic        req0_valid = 0, req0_we = 0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req0_ready, req0_err, req0_rvalid;
    logic [31:0] req0_rdata;
    logic        req1_valid = 0, req1_we = 0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req1_ready, req1_err, req1_rvalid;
    logic [31:0] req1_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_err(req0_err), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_err(req1_err), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // RAM model, one-cycle read latency. Reset refills known contents.
    // A read not strobed the cycle before returns a poison word.
    logic [31:0] ram [16];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'hA000_0000 + 32'(i);
            ram_q <= 32'hBAD0_BAD0;
        end else begin
            if (mem_wr) ram[mem_addr[5:2]] <= mem_wdata;
            ram_q <= mem_rd ? ram[mem_addr[5:2]] : 32'hBAD0_BAD0;
        end
    end
    assign mem_rdata = ram_q;

    // ---------------- DUT with RD_LAT=3 (port 1 idle) ----------------
    logic        v3 = 0;
    logic [31:0] a3 = '0;
    logic        p1_valid3 = 0, p1_we3 = 0, we3 = 0;
    logic [31:0] p1_addr3 = '0, p1_wdata3 = '0, wd3 = '0;
    logic        rdy3, err3, rv3, rdy3_1, err3_1, rv3_1, mem_rd3, mem_wr3;
    logic [31:0] rd3, rd3_1, mem_addr3, mem_wdata3, mem_rdata3;
    logic [31:0] p3 [3];

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(v3), .req0_we(we3), .req0_addr(a3), .req0_wdata(wd3),
        .req0_ready(rdy3), .req0_err(err3), .req0_rvalid(rv3), .req0_rdata(rd3),
        .req1_valid(p1_valid3), .req1_we(p1_we3), .req1_addr(p1_addr3), .req1_wdata(p1_wdata3),
        .req1_ready(rdy3_1), .req1_err(err3_1), .req1_rvalid(rv3_1), .req1_rdata(rd3_1),
        .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3)
    );

    // Three-stage read pipe: data for a read of A is ~A, valid 3 cycles after mem_rd.
    always @(posedge clk) begin
        p3[0] <= mem_rd3 ? ~mem_addr3 : 32'hBAD0_BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata3 = p3[2];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end
    endtask

    // Pulse counters and cross-port exclusivity, sampled mid-cycle.
    int rv0_cnt = 0, rv1_cnt = 0;
    always @(negedge clk) begin
        rv0_cnt += int'(req0_rvalid);
        rv1_cnt += int'(req1_rvalid);
        if ((req0_ready && req1_ready) || (req0_rvalid && req1_rvalid) || (mem_rd && mem_wr))
            check("pulse_overlap", 64'(1), 64'(0));
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } txn_t;

    // One complete transaction on an otherwise idle DUT.
    task automatic do_txn(input txn_t t);
        int          rv0_b, rv1_b, n;
        logic        got;
        logic [31:0] own_before;
        logic        rd_ok;
        rd_ok      = !t.we && !t.exp_err;
        rv0_b      = rv0_cnt;
        rv1_b      = rv1_cnt;
        own_before = t.port ? req1_rdata : req0_rdata;
        drive(t.port, 1'b1, t.we, t.addr, t.wdata);
        @(posedge clk); #1;
        check("tx_ready",       64'(t.port ? req1_ready : req0_ready), 64'(1));
        check("tx_other_ready", 64'(t.port ? req0_ready : req1_ready), 64'(0));
        check("tx_err",         64'(t.port ? req1_err : req0_err), 64'(t.exp_err));
        check("tx_mem_wr",      64'(mem_wr), 64'(t.we && !t.exp_err));
        check("tx_mem_rd",      64'(mem_rd), 64'(rd_ok));
        if (!t.exp_err) check("tx_mem_addr", 64'(mem_addr), 64'(t.addr));
        if (t.we && !t.exp_err) check("tx_mem_wdata", 64'(mem_wdata), 64'(t.wdata));
        drive(t.port, 1'b0, 1'b0, 32'h0, 32'h0);
        if (rd_ok) begin
            n = 0; got = 0;
            while (!got && n < 8) begin
                @(posedge clk); #1;
                n++;
                got = t.port ? req1_rvalid : req0_rvalid;
            end
            check("tx_rvalid_lat", 64'(n), 64'(2));
            check("tx_rdata", 64'(t.port ? req1_rdata : req0_rdata), 64'(t.exp_rdata));
        end else begin
            repeat (2) @(posedge clk);
            #1;
            check("tx_rdata_held", 64'(t.port ? req1_rdata : req0_rdata), 64'(own_before));
        end
        @(posedge clk); #1;
        check("tx_rv0_pulses", 64'(rv0_cnt - rv0_b), 64'((!t.port && rd_ok) ? 1 : 0));
        check("tx_rv1_pulses", 64'(rv1_cnt - rv1_b), 64'(( t.port && rd_ok) ? 1 : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        txn_t        vec [8];
        int          gseq [$];
        int          rv0_b, rv1_b;
        logic [31:0] r0_before;

        //                port we   addr        wdata          err  rdata
        vec[0] = '{1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vec[1] = '{1'b0, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vec[2] = '{1'b1, 1'b1, 32'h06, 32'h5555_AAAA, 1'b1, 32'h0};
        vec[3] = '{1'b1, 1'b1, 32'h08, 32'h1234_5678, 1'b0, 32'h0};
        vec[4] = '{1'b1, 1'b0, 32'h08, 32'h0,         1'b0, 32'h1234_5678};
        vec[5] = '{1'b0, 1'b0, 32'h03, 32'h0,         1'b1, 32'h0};
        vec[6] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vec[7] = '{1'b0, 1'b0, 32'h0C, 32'h0,         1'b0, 32'hA000_0003};

        // ---- reset values ----
        #12;
        check("rst_req0_ready", 64'(req0_ready), 64'(0));
        check("rst_mem_rd",     64'(mem_rd), 64'(0));
        check("rst_mem_wr",     64'(mem_wr), 64'(0));
        check("rst_mem_addr",   64'(mem_addr), 64'(0));
        check("rst_mem_wdata",  64'(mem_wdata), 64'(0));
        check("rst_rdata0",     64'(req0_rdata), 64'(0));
        check("rst_rdata1",     64'(req1_rdata), 64'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // ---- both ports valid every cycle: grants alternate, port 0 first ----
        rv0_b = rv0_cnt; rv1_b = rv1_cnt;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (req0_ready) gseq.push_back(0);
            if (req1_ready) gseq.push_back(1);
            if (req0_rvalid) check("alt_rdata0", 64'(req0_rdata), 64'(32'hA000_0000));
            if (req1_rvalid) check("alt_rdata1", 64'(req1_rdata), 64'(32'hA000_0001));
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("alt_grant_count", 64'(gseq.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            check("alt_grant_order", 64'((i < gseq.size()) ? gseq[i] : 9), 64'(i % 2));
        @(posedge clk); #1;
        check("alt_rv0_pulses", 64'(rv0_cnt - rv0_b), 64'(2));
        check("alt_rv1_pulses", 64'(rv1_cnt - rv1_b), 64'(2));

        // ---- table of single transactions ----
        for (int i = 0; i < 8; i++) do_txn(vec[i]);

        // ---- port 0 raises valid while port 1's read is in WAIT ----
        r0_before = req0_rdata;
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
        @(posedge clk); #1;
        check("ovl_ready1", 64'(req1_ready), 64'(1));
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;                        // WAIT
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;                        // RESP of port 1
        check("ovl_rvalid1", 64'(req1_rvalid), 64'(1));
        check("ovl_rdata1",  64'(req1_rdata), 64'(32'h1234_5678));
        check("ovl_ready0_resp", 64'(req0_ready), 64'(0));
        check("ovl_rdata0_hold", 64'(req0_rdata), 64'(r0_before));
        @(posedge clk); #1;                        // IDLE, port 0 granted here
        check("ovl_ready0_idle", 64'(req0_ready), 64'(0));
        @(posedge clk); #1;                        // ISSUE
        check("ovl_ready0", 64'(req0_ready), 64'(1));
        check("ovl_rdata0_hold2", 64'(req0_rdata), 64'(r0_before));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;                        // WAIT
        check("ovl_rdata0_hold3", 64'(req0_rdata), 64'(r0_before));
        @(posedge clk); #1;                        // RESP
        check("ovl_rvalid0", 64'(req0_rvalid), 64'(1));
        check("ovl_rdata0",  64'(req0_rdata), 64'(32'hA000_0000));
        @(posedge clk); #1;

        // ---- RD_LAT=3 read of 0x20 on the second instance ----
        v3 = 1'b1; a3 = 32'h20;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) check("l3_ready", 64'(rdy3), 64'(1));
            if (k == 1) v3 = 1'b0;
            check("l3_mem_rd", 64'(mem_rd3), 64'(k == 1));
            if (k <= 4) check("l3_mem_addr", 64'(mem_addr3), 64'(32'h20));
            check("l3_rvalid", 64'(rv3), 64'(k == 5));
            if (k == 5) check("l3_rdata", 64'(rd3), 64'(32'hFFFF_FFDF));
        end

        // ---- reset during WAIT of a port 0 read ----
        drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
        @(posedge clk); #1;                        // ISSUE
        check("rw_ready0", 64'(req0_ready), 64'(1));
        check("rw_mem_rd_issue", 64'(mem_rd), 64'(1));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;                        // WAIT
        check("rw_mem_addr_wait", 64'(mem_addr), 64'(32'h4));
        #2 rst = 1'b1;
        #1;
        check("rw_mem_addr_rst", 64'(mem_addr), 64'(0));
        check("rw_mem_rd_rst",   64'(mem_rd), 64'(0));
        check("rw_rdata0_rst",   64'(req0_rdata), 64'(0));
        rv0_b = rv0_cnt;
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rw_no_rvalid", 64'(rv0_cnt - rv0_b), 64'(0));
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(posedge clk); #1;
        check("rw_tie_ready0", 64'(req0_ready), 64'(1));
        check("rw_tie_ready1", 64'(req1_ready), 64'(0));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
